// File: rtl/bus_demux4.sv
// Routes one master bus transaction to one of four peripheral ports and returns its response.
// A per-transaction timeout keeps a dead port from stalling the master.
//
// state  | meaning
// IDLE   | waiting for m_req; s_* hold their last values
// ACCESS | s_req asserted on the latched port, counting toward timeout
// RESP   | one-cycle m_ack (and m_err on timeout) to the master
module bus_demux4 #(
    parameter int SEL_LSB = 10,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic [31:0] m_rdata,
    output logic        m_ack,
    output logic        m_err,
    output logic        m_busy,
    output logic [3:0]  s_req,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata0,
    input  logic [31:0] s_rdata1,
    input  logic [31:0] s_rdata2,
    input  logic [31:0] s_rdata3,
    input  logic [3:0]  s_ack
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [1:0]         r_port;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_rdata;
    logic               r_ack;
    logic               r_err;
    logic               r_busy;
    logic [3:0]         r_sreq;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;

    logic [1:0]         w_sel_port;
    logic               w_port_ack;
    logic               w_tmo;
    logic [31:0]        w_sel_rdata;

    assign w_sel_port = m_addr[SEL_LSB+1:SEL_LSB];
    assign w_port_ack = s_ack[r_port];
    assign w_tmo      = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_sel_rdata = s_rdata0;
        case (r_port)
            2'd0: w_sel_rdata = s_rdata0;
            2'd1: w_sel_rdata = s_rdata1;
            2'd2: w_sel_rdata = s_rdata2;
            2'd3: w_sel_rdata = s_rdata3;
            default: w_sel_rdata = s_rdata0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // An ack on the selected port outranks a timeout reached in the same cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m_req) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_port_ack || w_tmo) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_port  <= 2'd0;
            r_cnt   <= '0;
            r_rdata <= 32'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_sreq  <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_busy <= (w_next_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (m_req) begin
                        r_we    <= m_we;
                        r_addr  <= m_addr;
                        r_wdata <= m_wdata;
                        r_port  <= w_sel_port;
                        r_sreq  <= 4'b0001 << w_sel_port;
                        r_cnt   <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (w_port_ack) begin
                        r_sreq <= 4'd0;
                        r_ack  <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= w_sel_rdata;
                        end
                    end else if (w_tmo) begin
                        r_sreq  <= 4'd0;
                        r_rdata <= 32'd0;
                        r_ack   <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m_rdata = r_rdata;
    assign m_ack   = r_ack;
    assign m_err   = r_err;
    assign m_busy  = r_busy;
    assign s_req   = r_sreq;
    assign s_we    = r_we;
    assign s_addr  = r_addr;
    assign s_wdata = r_wdata;

endmodule

// File: tb/tb_bus_demux4.sv
// Bench for bus_demux4: directed scenarios plus random transactions checked
// against a transaction-level model of cycle counts, routing and response data.
module tb_bus_demux4;

    localparam int SEL = 10;
    localparam int TO  = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        m_err;
    logic        m_busy;
    logic [3:0]  s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [31:0] rd [4];
    logic [3:0]  s_ack;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_rdata;

    bus_demux4 #(.SEL_LSB(SEL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err), .m_busy(m_busy),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata0(rd[0]), .s_rdata1(rd[1]), .s_rdata2(rd[2]), .s_rdata3(rd[3]),
        .s_ack(s_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic rand_rdata();
        for (int i = 0; i < 4; i++) rd[i] = $urandom;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ack"},  32'(m_ack),  32'd0);
        chk({tag, "_err"},  32'(m_err),  32'd0);
        chk({tag, "_busy"}, 32'(m_busy), 32'd0);
        chk({tag, "_sreq"}, 32'(s_req),  32'd0);
    endtask

    // Starts at a negedge with the DUT idle; ack_k in 1..TO acks in that access
    // cycle, anything else never acks. Ends at a negedge with the DUT idle.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_k, input logic [31:0] ack_rdata, input bit noise);
        int          port;
        int          last;
        bit          tmo;
        logic [3:0]  oh;
        logic [31:0] cap;
        port = int'(addr[SEL+1:SEL]);
        oh   = 4'b0001 << port;
        tmo  = !(ack_k >= 1 && ack_k <= TO);
        last = tmo ? TO : ack_k;
        cap  = 32'd0;
        m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; s_ack = 4'd0;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            m_req = 1'b0; m_we = 1'($urandom); m_addr = $urandom; m_wdata = $urandom;
            chk("acc_sreq",  32'(s_req),  32'(oh));
            chk("acc_we",    32'(s_we),   32'(we));
            chk("acc_addr",  s_addr,      addr);
            chk("acc_wdata", s_wdata,     wdata);
            chk("acc_ack",   32'(m_ack),  32'd0);
            chk("acc_busy",  32'(m_busy), 32'd1);
            rand_rdata();
            if (noise) s_ack = (k == 1) ? ~oh : (4'($urandom) & ~oh);
            else       s_ack = 4'd0;
            if (k == ack_k) begin
                rd[port]    = ack_rdata;
                s_ack[port] = 1'b1;
                cap         = ack_rdata;
            end
        end
        if (tmo)      exp_rdata = 32'd0;
        else if (!we) exp_rdata = cap;
        @(negedge clk);
        chk("resp_ack",   32'(m_ack),  32'd1);
        chk("resp_err",   32'(m_err),  32'(tmo));
        chk("resp_rdata", m_rdata,     exp_rdata);
        chk("resp_sreq",  32'(s_req),  32'd0);
        chk("resp_busy",  32'(m_busy), 32'd1);
        s_ack = noise ? 4'($urandom) : 4'd0;
        @(negedge clk);
        chk_idle_outputs("post");
        chk("post_rdata", m_rdata, exp_rdata);
        s_ack = 4'd0;
    endtask

    initial begin
        logic [31:0] b2b_exp;
        logic [31:0] a;
        rst = 1'b1; m_req = 1'b1; m_we = 1'b1; m_addr = $urandom; m_wdata = $urandom;
        s_ack = 4'hF; rand_rdata();
        exp_rdata = 32'd0;
        @(negedge clk);
        m_addr = $urandom; m_wdata = $urandom; s_ack = 4'($urandom);
        @(negedge clk);
        chk_idle_outputs("rst");
        chk("rst_rdata", m_rdata, 32'd0);
        chk("rst_we",    32'(s_we), 32'd0);
        chk("rst_addr",  s_addr,    32'd0);
        chk("rst_wdata", s_wdata,   32'd0);
        rst = 1'b0; m_req = 1'b0; s_ack = 4'd0;
        @(negedge clk);
        chk_idle_outputs("rel");

        run_txn(1'b0, 32'h0000_0800, $urandom, 1, 32'h1234_5678, 1'b0);
        run_txn(1'b1, 32'h0000_0400, 32'hCAFE_F00D, 5, $urandom, 1'b0);
        run_txn(1'b0, 32'h0000_0C00, $urandom, 0, $urandom, 1'b0);
        run_txn(1'b0, 32'h0000_0C00, $urandom, TO, 32'hA5A5_5A5A, 1'b1);
        run_txn(1'b1, 32'h0000_0000, $urandom, 0, $urandom, 1'b1);

        // m_req held high with instant acks: accepted every third cycle
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0400; s_ack = 4'b0010;
        b2b_exp = exp_rdata;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            case (c % 3)
                0: begin
                    chk("b2b_sreq", 32'(s_req),  32'h2);
                    chk("b2b_ack",  32'(m_ack),  32'd0);
                end
                1: begin
                    chk("b2b_sreq",  32'(s_req), 32'd0);
                    chk("b2b_ack",   32'(m_ack), 32'd1);
                    chk("b2b_rdata", m_rdata,    b2b_exp);
                end
                default: begin
                    chk("b2b_busy", 32'(m_busy), 32'd0);
                    chk("b2b_ack",  32'(m_ack),  32'd0);
                end
            endcase
            rand_rdata();
            if (c % 3 == 0) b2b_exp = rd[1];
            if (c == 8) begin m_req = 1'b0; s_ack = 4'd0; end
        end
        exp_rdata = b2b_exp;
        @(negedge clk);
        chk_idle_outputs("b2b_end");

        // reset in the middle of an access abandons it
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0800; s_ack = 4'd0;
        @(negedge clk);
        m_req = 1'b0;
        @(negedge clk);
        chk("mr_sreq", 32'(s_req), 32'h4);
        rst = 1'b1; s_ack = 4'b0100;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("mr0");
        chk("mr_rdata", m_rdata, 32'd0);
        exp_rdata = 32'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_idle_outputs("mr");
        end
        s_ack = 4'd0;

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            run_txn(1'($urandom), a, $urandom, int'($urandom_range(0, TO + 2)),
                    $urandom, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_demux4.md
# bus_demux4

Routes one master memory-mapped bus transaction to one of four peripheral ports and returns that port's response. This is the request-side complement of the 32-bit 4:1 read-data selector used in the datapath.
- Decodes two address bits to pick a port and drives a one-hot request.
- Holds the request until the selected port acknowledges, then returns read data and a one-cycle acknowledge to the master.
- Sits between the CPU load/store unit and the memory-mapped I/O blocks, and includes a timeout so a dead port cannot hang the pipeline.

## Interface
Parameters:
- SEL_LSB, 10: low bit of the 2-bit port-select field, m_addr[SEL_LSB+1:SEL_LSB].
- TIMEOUT, 15: maximum number of cycles s_req is held without an acknowledge (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge; the only clock.
- rst  in  1  synchronous, active-high reset.
- m_req  in  1  master request; sampled only in IDLE.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  32  transaction address.
- m_wdata  in  32  write data.
- m_rdata  out  32  read data returned to master; registered.
- m_ack  out  1  one-cycle completion pulse.
- m_err  out  1  timeout flag; valid only while m_ack=1.
- m_busy  out  1  high whenever state ≠ IDLE.
- s_req  out  4  one-hot request; bit n = port n.
- s_we  out  1  latched m_we, shared by all ports.
- s_addr  out  32  latched m_addr, shared.
- s_wdata  out  32  latched m_wdata, shared.
- s_rdata0..s_rdata3  in  32 each  per-port read data.
- s_ack  in  4  per-port acknowledge.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP. All outputs are registered.
- **Reset:** at a rising edge with rst=1, state becomes IDLE and every output and internal register clears to 0, including the counter and the latched port.
  - A reset during ACCESS or RESP abandons the transaction: no m_ack, and s_req is 0 from the next cycle.
- **IDLE:**
  - If m_req=1: latch m_we, m_addr and m_wdata into s_we, s_addr and s_wdata; latch port = m_addr[SEL_LSB+1:SEL_LSB].
  - Then set s_req = 1<<port, clear the counter and go to ACCESS.
  - If m_req=0: stay in IDLE.
- **ACCESS:** s_req stays one-hot on the latched port, and s_we/s_addr/s_wdata are held stable.
  - If s_ack[port]=1:
    - Clear s_req.
    - On a read, load m_rdata from s_rdataN of the latched port; on a write, leave m_rdata unchanged.
    - Set m_ack=1, m_err=0 and go to RESP.
  - Otherwise, if counter == TIMEOUT-1: clear s_req, set m_rdata=0, m_ack=1, m_err=1 and go to RESP.
  - Otherwise: increment the counter.
  - Acks on non-selected ports are ignored in every state.
  - If an ack arrives in the same cycle the counter reaches TIMEOUT-1, the ack wins: normal completion with m_err=0.
- **RESP:** m_ack (and m_err if set) is high for exactly this one cycle.
  - Next state is IDLE, with m_ack and m_err cleared.
  - m_req is not sampled in RESP.
- m_rdata holds its value until the next read completion, timeout or reset.
- The master need not hold m_addr, m_we or m_wdata after its request is accepted.
- s_* outputs keep their last value in IDLE; only s_req qualifies them.

## Timing
- Request sampled in IDLE at edge T; s_req is high from T+1.
- A slave acking in the first ACCESS cycle (observed at edge T+2) gives m_ack high in cycle T+2.
  - Minimum latency is 2 cycles, request to m_ack.
  - Minimum issue interval is 3 cycles; the next request is accepted at edge T+3.
- Slave ack in ACCESS cycle k (k=1 is the first s_req cycle): m_ack in cycle k+1 after T; s_req is low in that same cycle.
- Timeout with no ack: s_req is high for exactly TIMEOUT cycles (T+1 … T+TIMEOUT); m_ack=m_err=1 in cycle T+TIMEOUT+1.
- m_busy is high from T+1 through the RESP cycle inclusive.

## Test plan
- **Reset:** hold rst 2 cycles with random inputs → all outputs 0 and m_busy=0 afterward.
- **Read, fast ack:** read with m_addr=0x0000_0800 (SEL_LSB=10 → port 2); port 2 acks in its first s_req cycle with s_rdata2=0x1234_5678 → s_req=4'b0100 for 1 cycle; m_ack at T+2 with m_rdata=0x1234_5678, m_err=0.
- **Write with wait states:** write to port 1 (addr 0x400, wdata 0xCAFE_F00D); ack after 5 cycles → s_we=1, s_addr=0x400, s_wdata=0xCAFE_F00D held stable for all 5 cycles; m_ack=1, m_err=0; m_rdata unchanged.
- **Timeout:** read to port 3 with no ack, TIMEOUT=15 → s_req=4'b1000 for exactly 15 cycles; m_ack=m_err=1 at T+16; m_rdata=0.
- **Wrong-port ack and timeout race:**
  - Port 0 acks while port 3 is selected → ignored.
  - Port 3 acks in the 15th s_req cycle → normal completion, m_err=0.
- **Back-to-back and mid-transaction reset:**
  - m_req held high continuously → requests accepted every 3 cycles.
  - rst asserted in ACCESS → s_req=0 next cycle, no m_ack.
